// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants shared by the multi-cycle control FSM and its users.
// Holds the opcode map, the FSM state encoding, the alu_op and wb_sel codes,
// and two small helpers: sign-extension of imm7 and opcode -> ALU control.
package cpu_pkg;

  // Opcode field ir[15:13]
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_t;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // alu_op codes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_NAND  = 2'b01;
  localparam logic [1:0] ALU_LUI   = 2'b10;  // pass imm10 << 6
  localparam logic [1:0] ALU_PASSB = 2'b11;

  // wb_sel codes
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic       src_imm;
  } alu_ctl_t;

  function automatic logic [15:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

  // LW/SW compute their address as ra + sext(imm7), hence the immediate.
  // BEQ leaves the ALU on add; the equality comes from the datapath's eq.
  function automatic alu_ctl_t alu_decode(input opcode_t opc);
    alu_ctl_t c;
    c.op      = ALU_ADD;
    c.src_imm = 1'b0;
    case (opc)
      OP_ADDI, OP_SW, OP_LW: c.src_imm = 1'b1;
      OP_NAND:               c.op      = ALU_NAND;
      OP_LUI:                c.op      = ALU_LUI;
      OP_JALR:               c.op      = ALU_PASSB;
      default:               ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if -- memory request/acknowledge bus of the control FSM.
//   mem_req   : request, held until mem_ack
//   mem_we    : request is a write
//   mem_ack   : memory completes the current request this cycle
//   mem_rdata : read data, valid with mem_ack
// master = controller side, slave = memory side.
interface control_fsm_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle controller for a 16-bit, 8-instruction core.
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH and
// owns pc, ir, the JALR link register and the load-data latch.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : leave IDLE and begin fetching at pc
//   eq           : datapath compare ra == rb (used by BEQ in EXEC)
//   alu_result   : ALU output; in EXEC of JALR it carries rb (pass-b)
//   mem          : memory request bus (master side)
//   pc, ir       : program counter, instruction register
//   link         : pc+1 captured by JALR, written back with wb_sel=10
//   mdr          : mem_rdata latched by LW, written back with wb_sel=01
//   addr_sel     : 0 = memory address is pc, 1 = ALU result
//   alu_op, alu_src_imm : ALU controls
//   reg_we, reg_wsel, wb_sel : register-file write port controls
//   halted       : core stopped until reset
module control_fsm
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC         = 16'h0000,
  parameter bit          HALT_ON_JALR_IMM = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                eq,
  input  logic [15:0]         alu_result,
  control_fsm_if.master       mem,
  output logic [15:0]         pc,
  output logic [15:0]         ir,
  output logic [15:0]         link,
  output logic [15:0]         mdr,
  output logic                addr_sel,
  output logic [1:0]          alu_op,
  output logic                alu_src_imm,
  output logic                reg_we,
  output logic [2:0]          reg_wsel,
  output logic [1:0]          wb_sel,
  output logic                halted
);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc,   w_pc_next;
  logic [15:0] r_ir,   w_ir_next;
  logic [15:0] r_link, w_link_next;
  logic [15:0] r_mdr,  w_mdr_next;
  opcode_t     w_opcode;
  logic [6:0]  w_imm7;
  alu_ctl_t    w_alu;
  logic        w_mem_req;
  logic        w_mem_we;

  assign w_opcode = opcode_t'(r_ir[15:13]);
  assign w_imm7   = r_ir[6:0];
  assign w_alu    = alu_decode(w_opcode);

  // State and datapath registers. Reset is asynchronous so that mem_req,
  // decoded from r_state, drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_link  <= '0;
      r_mdr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_link  <= w_link_next;
      r_mdr   <= w_mdr_next;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_link_next  = r_link;
    w_mdr_next   = r_mdr;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.mem_ack) begin
          w_ir_next    = mem.mem_rdata;
          w_pc_next    = r_pc + 16'd1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: w_state_next = ST_EXEC;
      ST_EXEC: begin
        case (w_opcode)
          OP_SW, OP_LW: w_state_next = ST_MEM;
          OP_BEQ: begin
            // r_pc already points past the branch, so the offset is
            // relative to the next instruction.
            if (eq) w_pc_next = r_pc + sext7(w_imm7);
            w_state_next = ST_FETCH;
          end
          OP_JALR: begin
            if (HALT_ON_JALR_IMM && (w_imm7 != 7'd0)) begin
              w_state_next = ST_HALT;
            end else begin
              w_link_next  = r_pc;
              w_pc_next    = alu_result;
              w_state_next = ST_WB;
            end
          end
          default: w_state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem.mem_ack) begin
          if (w_opcode == OP_SW) begin
            w_state_next = ST_FETCH;
          end else begin
            w_mdr_next   = mem.mem_rdata;
            w_state_next = ST_WB;
          end
        end
      end
      ST_WB:   w_state_next = ST_FETCH;
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state. The ALU controls stay driven
  // through MEM and WB so the address / result remains valid while used.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    addr_sel    = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: w_mem_req = 1'b1;
      ST_EXEC: begin
        alu_op      = w_alu.op;
        alu_src_imm = w_alu.src_imm;
      end
      ST_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_we    = (w_opcode == OP_SW);
        addr_sel    = 1'b1;
        alu_op      = w_alu.op;
        alu_src_imm = w_alu.src_imm;
      end
      ST_WB: begin
        alu_op      = w_alu.op;
        alu_src_imm = w_alu.src_imm;
        // r0 is hard-wired to zero, so writes to it are dropped
        reg_we      = (r_ir[12:10] != 3'd0);
        if (w_opcode == OP_LW)        wb_sel = WB_MEM;
        else if (w_opcode == OP_JALR) wb_sel = WB_LINK;
        else                          wb_sel = WB_ALU;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_req = w_mem_req;
  assign mem.mem_we  = w_mem_we;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign link        = r_link;
  assign mdr         = r_mdr;
  assign reg_wsel    = r_ir[12:10];

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm -- randomized bench for control_fsm against an
// instruction-level model: for every instruction the bench knows the
// cycle-by-cycle bus activity it implies and the architectural effect on
// pc / ir / link / mdr / halted.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        eq = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic [15:0] pc, ir, link, mdr;
  logic        addr_sel, alu_src_imm, reg_we, halted;
  logic [1:0]  alu_op, wb_sel;
  logic [2:0]  reg_wsel;

  control_fsm_if bus ();

  control_fsm #(
    .RESET_PC        (16'h0000),
    .HALT_ON_JALR_IMM(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .eq         (eq),
    .alu_result (alu_result),
    .mem        (bus),
    .pc         (pc),
    .ir         (ir),
    .link       (link),
    .mdr        (mdr),
    .addr_sel   (addr_sel),
    .alu_op     (alu_op),
    .alu_src_imm(alu_src_imm),
    .reg_we     (reg_we),
    .reg_wsel   (reg_wsel),
    .wb_sel     (wb_sel),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_chk;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        wb_chk;
    logic        halted;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] link;
    logic [15:0] mdr;
  } exp_t;

  exp_t        exp_q;
  logic        exp_valid = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          we_pulses = 0;
  int          req_cycles = 0;
  int          last_cycles = 0;

  // architectural model state
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ir = 16'h0000;
  logic [15:0] m_link = 16'h0000;
  logic [15:0] m_mdr = 16'h0000;
  logic        m_halted = 1'b0;

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endfunction

  // Operation class per opcode: {alu_op, alu_src_imm}
  function automatic logic [2:0] alu_exp(input logic [2:0] op);
    case (op)
      3'd1, 3'd4, 3'd5: return 3'b001;  // ADDI, SW, LW: ra + imm
      3'd2:             return 3'b010;  // NAND
      3'd3:             return 3'b100;  // LUI
      3'd7:             return 3'b110;  // JALR: pass rb
      default:          return 3'b000;  // ADD, BEQ
    endcase
  endfunction

  function automatic exp_t base();
    exp_t e;
    e        = '0;
    e.pc     = m_pc;
    e.ir     = m_ir;
    e.link   = m_link;
    e.mdr    = m_mdr;
    e.halted = m_halted;
    return e;
  endfunction

  // The single per-cycle compare process
  always @(negedge clk) begin
    if (exp_valid && rst_n) begin
      chk("mem_req",  16'(bus.mem_req), 16'(exp_q.mem_req));
      chk("mem_we",   16'(bus.mem_we),  16'(exp_q.mem_we));
      chk("addr_sel", 16'(addr_sel),    16'(exp_q.addr_sel));
      chk("reg_we",   16'(reg_we),      16'(exp_q.reg_we));
      chk("reg_wsel", 16'(reg_wsel),    16'(exp_q.ir[12:10]));
      chk("halted",   16'(halted),      16'(exp_q.halted));
      chk("pc",       pc,               exp_q.pc);
      chk("ir",       ir,               exp_q.ir);
      chk("link",     link,             exp_q.link);
      chk("mdr",      mdr,              exp_q.mdr);
      if (exp_q.alu_chk) begin
        chk("alu_op",      16'(alu_op),      16'(exp_q.alu_op));
        chk("alu_src_imm", 16'(alu_src_imm), 16'(exp_q.alu_src_imm));
      end
      if (exp_q.wb_chk) chk("wb_sel", 16'(wb_sel), 16'(exp_q.wb_sel));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we)      we_pulses  <= we_pulses + 1;
      if (bus.mem_req) req_cycles <= req_cycles + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs that must have no effect in the current state
  task automatic noise();
    start         = 1'($urandom);
    eq            = 1'($urandom);
    alu_result    = 16'($urandom);
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
  endtask

  task automatic go_idle(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      start     = (k == n - 1);
      exp_q     = base();
      exp_valid = 1'b1;
      tick();
    end
  endtask

  // Called at posedge+1; reasserts reset, checks the reset values, restarts.
  task automatic reset_and_start(input int idle_n);
    #1 rst_n = 1'b0;
    exp_valid = 1'b0;
    m_pc = 16'h0000; m_ir = '0; m_link = '0; m_mdr = '0; m_halted = 1'b0;
    #1;
    chk("rst_mem_req", 16'(bus.mem_req), 16'h0000);
    chk("rst_pc",      pc,               16'h0000);
    chk("rst_ir",      ir,               16'h0000);
    chk("rst_halted",  16'(halted),      16'h0000);
    tick();
    rst_n = 1'b1;
    go_idle(idle_n);
  endtask

  task automatic halt_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      noise();
      exp_q = base();
      tick();
    end
  endtask

  // Runs one instruction starting in a FETCH cycle (posedge+1).
  // fdly/mdly: cycles of withheld ack in FETCH/MEM. rm: reset during MEM.
  task automatic run_instr(input logic [15:0] instr, input int fdly, input int mdly,
                           input logic eqv, input logic [15:0] rbv, input logic rm);
    exp_t        e;
    logic [2:0]  op;
    logic [15:0] simm;
    logic [15:0] d;
    op          = instr[15:13];
    simm        = {{9{instr[6]}}, instr[6:0]};
    last_cycles = 0;
    for (int k = 0; k <= fdly; k++) begin
      noise();
      bus.mem_ack   = (k == fdly);
      bus.mem_rdata = (k == fdly) ? instr : 16'($urandom);
      e = base(); e.mem_req = 1'b1;
      exp_q = e; tick(); last_cycles++;
    end
    m_ir = instr;
    m_pc = m_pc + 16'd1;
    // decode
    noise();
    exp_q = base(); tick(); last_cycles++;
    // execute
    noise();
    eq = eqv; alu_result = rbv;
    e = base(); {e.alu_op, e.alu_src_imm} = alu_exp(op); e.alu_chk = 1'b1;
    exp_q = e; tick(); last_cycles++;
    if (op == 3'd6) begin
      if (eqv) m_pc = m_pc + simm;
      return;
    end
    if (op == 3'd7) begin
      if (instr[6:0] != 7'd0) begin
        m_halted = 1'b1;
        return;
      end
      m_link = m_pc;
      m_pc   = rbv;
    end
    if (op == 3'd4 || op == 3'd5) begin
      for (int k = 0; k <= mdly; k++) begin
        noise();
        d = 16'($urandom);
        bus.mem_ack   = (k == mdly) && !rm;
        bus.mem_rdata = d;
        e = base(); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (op == 3'd4);
        exp_q = e;
        if (rm) begin
          // asynchronous reset while the request is outstanding
          #2 rst_n = 1'b0;
          #1;
          chk("rstmem_mem_req", 16'(bus.mem_req), 16'h0000);
          chk("rstmem_pc",      pc,               16'h0000);
          exp_valid = 1'b0;
          m_pc = 16'h0000; m_ir = '0; m_link = '0; m_mdr = '0; m_halted = 1'b0;
          chk("rstmem_idle_req", 16'(bus.mem_req), 16'h0000);
          return;
        end
        tick(); last_cycles++;
        if (k == mdly && op == 3'd5) m_mdr = d;
      end
      if (op == 3'd4) return;
    end
    // write-back
    noise();
    e = base();
    e.reg_we = (instr[12:10] != 3'd0);
    e.wb_sel = (op == 3'd5) ? 2'b01 : ((op == 3'd7) ? 2'b10 : 2'b00);
    e.wb_chk = 1'b1;
    exp_q = e; tick(); last_cycles++;
  endtask

  int c_we, c_req;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    tick();
    reset_and_start(3);

    // ADDI r1,r1,5 with immediate ack: FETCH..WB is 4 cycles, 5th is FETCH
    c_we = we_pulses;
    run_instr(16'h2485, 0, 0, 1'b0, 16'h0000, 1'b0);
    chk("addi_pc",     pc,                  16'h0001);
    chk("addi_ir",     ir,                  16'h2485);
    chk("addi_cycles", 16'(last_cycles),    16'd4);
    chk("addi_we",     16'(we_pulses - c_we), 16'd1);

    // fetch with ack delayed 3 cycles: request held 4 cycles
    c_req = req_cycles;
    run_instr(16'h0881, 3, 0, 1'b0, 16'h0000, 1'b0);
    chk("fetch_hold", 16'(req_cycles - c_req), 16'd4);

    for (int k = 0; k < 3; k++) run_instr(16'h2485, 0, 0, 1'b0, 16'h0000, 1'b0);
    chk("pc_before_beq", pc, 16'h0005);

    // BEQ imm7=-2 taken from pc=5
    c_we = we_pulses;
    run_instr(16'hC07E, 0, 0, 1'b1, 16'h0000, 1'b0);
    chk("beq_taken_pc", pc, 16'h0004);
    chk("beq_no_we",    16'(we_pulses - c_we), 16'd0);
    run_instr(16'h0881, 0, 0, 1'b0, 16'h0000, 1'b0);
    run_instr(16'hC07E, 1, 0, 1'b0, 16'h0000, 1'b0);
    chk("beq_not_taken_pc", pc, 16'h0006);

    // LW to r0: memory access but no write strobe
    c_we = we_pulses; c_req = req_cycles;
    run_instr(16'hA003, 0, 2, 1'b0, 16'h0000, 1'b0);
    chk("lw_r0_no_we", 16'(we_pulses - c_we), 16'd0);
    chk("lw_r0_req",   16'(req_cycles - c_req), 16'd4);

    run_instr(16'hAC00, 0, 1, 1'b0, 16'h0000, 1'b0);  // LW r3
    run_instr(16'h8503, 2, 1, 1'b0, 16'h0000, 1'b0);  // SW
    // JALR imm7=0 fetched at pc=9: link = 10, pc = rb
    run_instr(16'hE500, 0, 0, 1'b0, 16'h1234, 1'b0);
    chk("jalr_pc",   pc,   16'h1234);
    chk("jalr_link", link, 16'h000A);

    // JALR imm7=1 halts; nothing more happens for 20 cycles
    run_instr(16'hE501, 0, 0, 1'b0, 16'hBEEF, 1'b0);
    chk("halt_flag", 16'(halted), 16'h0001);
    c_req = req_cycles;
    halt_cycles(20);
    chk("halt_no_req", 16'(req_cycles - c_req), 16'd0);
    chk("halt_pc",     pc, 16'h1235);

    // reset while a load waits for its ack
    reset_and_start(2);
    run_instr(16'hAC00, 1, 3, 1'b0, 16'h0000, 1'b1);
    tick();
    reset_and_start(2);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ins;
      logic        rm;
      ins = 16'($urandom);
      if (ins[15:13] == 3'b111 && $urandom_range(0, 3) != 0) ins[6:0] = 7'd0;
      rm = (ins[15:13] == 3'b100 || ins[15:13] == 3'b101) && ($urandom_range(0, 9) == 0);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 16'($urandom), rm);
      if (rm) begin
        tick();
        reset_and_start(1 + $urandom_range(0, 2));
      end else if (m_halted) begin
        halt_cycles(3);
        reset_and_start(2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter HALT_ON_JALR_IMM, 1, when 1 a JALR with imm7 != 0 halts the core.
REQ-003 Clock and reset: one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  leave IDLE and begin fetching at current PC.
REQ-007 mem_ack  input  1  memory completes the current request this cycle.
REQ-008 mem_rdata  input  16  memory read data, valid when mem_ack=1.
REQ-009 eq  input  1  datapath compare, ra value == rb value.
REQ-010 pc  output  16  program counter.
REQ-011 ir  output  16  instruction register, feeds the operand decoder.
REQ-012 mem_req  output  1  memory request, held until mem_ack.
REQ-013 mem_we  output  1  request is a write (SW).
REQ-014 addr_sel  output  1  0 = address is pc, 1 = address is ALU result.
REQ-015 alu_op  output  2  00 add, 01 nand, 10 pass-imm10<<6 (LUI), 11 pass-b.
REQ-016 alu_src_imm  output  1  ALU B operand is sign-extended imm7.
REQ-017 reg_we  output  1  register-file write strobe, one cycle.
REQ-018 reg_wsel  output  3  destination register, always ir[12:10].
REQ-019 wb_sel  output  2  00 ALU, 01 mem_rdata latch, 10 pc (JALR link).
REQ-020 halted  output  1  core stopped.

Function
REQ-021 Opcode is ir[15:13]: 000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 SW, 101 LW, 110 BEQ, 111 JALR.
REQ-022 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, encoded in a 3-bit register.
REQ-023 IDLE -> FETCH when start=1; otherwise stay.
REQ-024 FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ack, ir <= mem_rdata, pc <= pc+1 (mod 2^16), go DECODE; without ack, stay with outputs stable.
REQ-025 DECODE: one cycle, no strobes, go EXEC.
REQ-026 EXEC: drive alu_op/alu_src_imm per opcode; LW/SW -> MEM; BEQ -> FETCH, pc <= pc + sext(imm7) if eq=1; JALR -> HALT if HALT_ON_JALR_IMM=1 and imm7!=0, else pc <= rb value (via alu pass-b), go WB; others -> WB.
REQ-027 JALR link SHALL write the already-incremented pc (old pc, before jump) captured in EXEC into a link register used by wb_sel=10.
REQ-028 MEM: mem_req=1, addr_sel=1, mem_we=1 for SW; on mem_ack, SW -> FETCH, LW latches mem_rdata -> WB; without ack, stay.
REQ-029 WB: reg_we=1 for exactly one cycle, then FETCH.
REQ-030 reg_we SHALL be suppressed when ir[12:10]=000 (r0 reads zero).
REQ-031 All branch/add arithmetic SHALL be 16-bit, wrap-around, imm7 sign-extended from bit 6.
REQ-032 HALT: all strobes 0, halted=1; stays until reset.
REQ-033 start while not in IDLE SHALL be ignored.
REQ-034 mem_ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, pc=RESET_PC, ir=0, link=0, mem_req=0, mem_we=0, reg_we=0, halted=0, all select outputs 0.
REQ-036 Reset asserted mid-request SHALL drop mem_req in the same instant; the pending ack is discarded.

Structure
REQ-037 Opcode constants, state encoding, alu_op and wb_sel codes SHALL live in a shared package cpu_pkg.
REQ-038 No sub-module required; the operand decoder remains a separate instance driven by ir.

Verification
REQ-039 Reset, start=1, mem returns 16'h2485 (ADDI r1,r1,5) with 0-cycle ack -> reg_we pulses in WB with reg_wsel=1, pc=1, 5 cycles FETCH-to-FETCH.
REQ-040 FETCH with mem_ack delayed 3 cycles -> mem_req held 4 cycles, ir unchanged until ack.
REQ-041 BEQ imm7=7'h7E at pc=5, eq=1 -> pc=16'h0004 after EXEC; eq=0 -> pc=16'h0006; no reg_we.
REQ-042 LW to r0 -> mem_req in MEM with addr_sel=1, no reg_we pulse.
REQ-043 JALR imm7=1 -> halted=1, no further mem_req for 20 cycles; start ignored.
REQ-044 rst_n low during MEM wait -> mem_req=0 asynchronously, state IDLE, pc=RESET_PC.
